dm_bridge: RTL
==============

Name: dm_bridge

Overview:
- Sits directly downstream of the single-cycle CPU core's data-memory port (DM_enable/DM_read/DM_write/DM_address/DM_in/DM_out).
- Converts the core's one-cycle DM access into a req/ack handshake toward a multi-cycle data SRAM/bus.
- Stalls the core until each access completes.
- Captures read data into a registered DM_out, enforces an ack timeout and flags bus errors.

Parameters:
ADDR_W, 12, width of DM_address / mem_addr
DATA_W, 32, width of data paths
TIMEOUT, 255, max cycles mem_req may stay high without mem_ack before abort (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset; synchronous, active-low
DM_enable  input  1  core data-memory access enable
DM_read  input  1  core load request
DM_write  input  1  core store request
DM_address  input  ADDR_W  core access address
DM_in  input  DATA_W  core store data
DM_out  output  DATA_W  load data returned to core (registered)
stall  output  1  high: core must hold PC and DM request
mem_req  output  1  request to memory, held until mem_ack or timeout
mem_we  output  1  1=write, 0=read; valid while mem_req
mem_addr  output  ADDR_W  latched address; valid while mem_req
mem_wdata  output  DATA_W  latched store data; valid while mem_req
mem_rdata  input  DATA_W  read data, valid in mem_ack cycle
mem_ack  input  1  one-cycle completion pulse from memory
bus_err  output  1  sticky timeout flag

Behaviour:
- Reset (rst==0 at clk edge): state=IDLE, DM_out=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, bus_err=0, timeout counter=0. Reset mid-transaction aborts at that edge; no completion reported; mem_req low the next cycle.
- States: IDLE, REQ, DONE.
- IDLE:
  - Access valid = DM_enable && (DM_read || DM_write).
  - On valid access: stall=1 combinationally in the same cycle. At the edge: latch mem_addr=DM_address, mem_wdata=DM_in, mem_we=DM_write; counter=0; go REQ.
  - DM_read && DM_write both high: treated as write (write priority).
  - DM_enable with neither read nor write: no access, stall=0.
  - mem_ack in IDLE or DONE: ignored.
- REQ:
  - mem_req=1, stall=1; mem_addr/mem_we/mem_wdata stable throughout.
  - mem_ack sampled high: for a read, DM_out<=mem_rdata; for a write, DM_out unchanged. Go DONE; mem_req low from the next cycle.
  - No ack: counter increments. At counter==TIMEOUT-1 without ack: bus_err<=1, DM_out<=0 if read, go DONE.
  - mem_ack in the same cycle as timeout expiry: ack wins, no error.
- DONE:
  - stall=0, mem_req=0. The core completes the instruction at this edge with DM_out valid.
  - Always returns to IDLE; the DM request still present in this cycle is NOT re-accepted.
- Latency: ack in first REQ cycle gives 2 stall cycles (IDLE-accept, REQ), then DONE. Each extra ack wait cycle adds one stall cycle.
- bus_err is cleared only by reset.
- DM_out holds its last value between accesses.
- Throughput: at most one access per 3 cycles.

Test Plan:
1. Reset: hold rst=0 2 cycles with DM_enable=1, DM_read=1 -> all outputs 0, stall=0, mem_req=0 throughout.
2. Read, immediate ack: DM_read @0x3A4; ack next cycle with mem_rdata=0xDEADBEEF -> stall high 2 cycles, mem_req 1 cycle with mem_we=0, mem_addr=0x3A4; DM_out=0xDEADBEEF in DONE; bus_err=0.
3. Write, ack after 4 wait cycles: DM_write @0x010, DM_in=0x12345678 -> mem_req high 5 cycles, mem_we=1, mem_wdata=0x12345678 stable; stall 6 cycles; DM_out unchanged.
4. Timeout with TIMEOUT=4: read, never ack -> mem_req high exactly 4 cycles; bus_err=1 and DM_out=0 in DONE; bus_err stays 1 over later good accesses until rst=0.
5. Read+write both high, DM_in=0xA5A5A5A5 -> mem_we=1 write issued; then request held through DONE -> no second transaction, returns to IDLE.
6. Reset mid-REQ (cycle 2 of a waiting read) -> mem_req=0 next cycle, state IDLE; a late mem_ack afterwards has no effect on DM_out.

Source files
------------

// File: rtl/dm_bridge.sv
// Bridges the single-cycle core's data-memory port onto a req/ack memory bus.
// The core is stalled while a request is outstanding; ack timeouts set a sticky bus error.
module dm_bridge #(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              DM_enable,
   input  logic              DM_read,
   input  logic              DM_write,
   input  logic [ADDR_W-1:0] DM_address,
   input  logic [DATA_W-1:0] DM_in,
   output logic [DATA_W-1:0] DM_out,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              bus_err
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0]   dm_out_q, dm_out_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                bus_err_q, bus_err_d;
   logic                access_valid;
   logic                timeout_hit;

   assign access_valid = DM_enable && (DM_read || DM_write);
   assign timeout_hit  = (cnt_q == CntW'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dm_out_d    = dm_out_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      bus_err_d   = bus_err_q;
      case (state_q)
         StIdle: begin
            if (access_valid) begin
               // Write wins when read and write are both asserted.
               mem_addr_d  = DM_address;
               mem_wdata_d = DM_in;
               mem_we_d    = DM_write;
               cnt_d       = '0;
               state_d     = StReq;
            end
         end
         StReq: begin
            if (mem_ack) begin
               if (!mem_we_q) dm_out_d = mem_rdata;
               state_d = StDone;
            end else if (timeout_hit) begin
               bus_err_d = 1'b1;
               if (!mem_we_q) dm_out_d = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         // The request still held by the core here belongs to the finished instruction.
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         dm_out_q    <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dm_out_q    <= dm_out_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign stall     = rst && (((state_q == StIdle) && access_valid) || (state_q == StReq));
   assign mem_req   = (state_q == StReq);
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign DM_out    = dm_out_q;
   assign bus_err   = bus_err_q;

endmodule
